// File: rtl/alu_mdu_seq.sv
// ---------------------------------------------------------------------------
// alu_mdu_seq
//
// Handshaked integer execute unit: single-cycle ALU operations plus an
// iterative radix-2 multiply/divide unit behind one valid/ready request and
// one valid/ready response channel. The result is registered and held until
// the consumer takes it.
//
// Optional feature macro: ALU_DIV_EARLY_EN
//   defined   - divide-by-zero and signed-overflow divides/remainders finish
//               straight from IDLE (latency 1)
//   undefined - those cases run the full iterative sequence (latency XLEN+1);
//               results are identical either way
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   io_req_valid   request present
//   io_req_ready   request can be accepted this cycle (combinational from
//                  io_resp_ready and io_kill)
//   io_req_md      0 = ALU op, 1 = multiply/divide op
//   io_req_fn      opcode
//   io_req_in1/2   operands, captured at acceptance
//   io_kill        abort the in-flight operation / pending response
//   io_resp_valid  result available
//   io_resp_ready  consumer takes the result
//   io_resp_data   result
//   io_resp_adder  in1 +/- in2 of the accepted ALU op, 0 for md ops
//   io_busy        FSM not idle
// ---------------------------------------------------------------------------
module alu_mdu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_req_valid,
  output logic            io_req_ready,
  input  logic            io_req_md,
  input  logic [3:0]      io_req_fn,
  input  logic [XLEN-1:0] io_req_in1,
  input  logic [XLEN-1:0] io_req_in2,
  input  logic            io_kill,
  output logic            io_resp_valid,
  input  logic            io_resp_ready,
  output logic [XLEN-1:0] io_resp_data,
  output logic [XLEN-1:0] io_resp_adder,
  output logic            io_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SHW:0] COUNT_INIT = (SHW+1)'(XLEN);
  localparam logic [SHW:0] COUNT_ONE  = (SHW+1)'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_reg, state_next;
  logic [SHW:0]        count_reg, count_next;
  logic [2:0]          fn_reg, fn_next;
  logic                prod_neg_reg, prod_neg_next;   // negate product / quotient
  logic                rem_neg_reg, rem_neg_next;     // negate remainder
  logic [2*XLEN-1:0]   acc_reg, acc_next;             // {hi, lo} working register
  logic [XLEN-1:0]     mcand_reg, mcand_next;         // multiplicand or divisor magnitude
  logic [XLEN-1:0]     resp_data_reg, resp_data_next;
  logic [XLEN-1:0]     resp_adder_reg, resp_adder_next;

  // -------------------------------------------------------------------------
  // Request handshake
  // -------------------------------------------------------------------------
  logic req_ready;
  logic accept;

  assign req_ready = ~io_kill & ((state_reg == IDLE) |
                                 ((state_reg == DONE) & io_resp_ready));
  assign accept    = io_req_valid & req_ready;

  // -------------------------------------------------------------------------
  // ALU datapath (works directly on the request operands)
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] alu_in2_eff;
  logic [XLEN-1:0] alu_sum;
  logic [XLEN-1:0] alu_result;
  logic [SHW-1:0]  shamt;
  logic            alu_lt;

  // fn[3] turns the adder into a subtractor: in1 + ~in2 + 1
  assign alu_in2_eff = io_req_fn[3] ? ~io_req_in2 : io_req_in2;
  assign alu_sum     = io_req_in1 + alu_in2_eff + {{(XLEN-1){1'b0}}, io_req_fn[3]};
  assign shamt       = io_req_in2[SHW-1:0];

  // With equal operand signs the difference sign decides; otherwise the
  // negative operand is the smaller one (signed) or the larger one (unsigned).
  // fn[1] distinguishes SLTU (14) from SLT (12).
  always_comb begin
    alu_lt = alu_sum[XLEN-1];
    if (io_req_in1[XLEN-1] != io_req_in2[XLEN-1]) begin
      alu_lt = io_req_fn[1] ? io_req_in2[XLEN-1] : io_req_in1[XLEN-1];
    end
  end

  always_comb begin
    alu_result = io_req_in1;
    case (io_req_fn)
      4'd0:        alu_result = alu_sum;
      4'd1:        alu_result = io_req_in1 << shamt;
      4'd4:        alu_result = io_req_in1 ^ io_req_in2;
      4'd5:        alu_result = io_req_in1 >> shamt;
      4'd6:        alu_result = io_req_in1 | io_req_in2;
      4'd7:        alu_result = io_req_in1 & io_req_in2;
      4'd10:       alu_result = alu_sum;
      4'd11:       alu_result = $unsigned($signed(io_req_in1) >>> shamt);
      4'd12, 4'd14: alu_result = {{(XLEN-1){1'b0}}, alu_lt};
      default:     alu_result = io_req_in1;
    endcase
  end

  // -------------------------------------------------------------------------
  // MD operand conditioning at acceptance: the iterative core works on
  // unsigned magnitudes; signs are reapplied in the last iteration.
  // -------------------------------------------------------------------------
  logic            req_mul;
  logic            req_a_signed, req_b_signed;
  logic            req_a_neg, req_b_neg;
  logic            req_b_zero;
  logic [XLEN-1:0] req_a_mag, req_b_mag;

  assign req_mul      = ~io_req_fn[2];
  assign req_a_signed = req_mul ? ((io_req_fn[1:0] == 2'd1) | (io_req_fn[1:0] == 2'd2))
                                : ~io_req_fn[0];
  assign req_b_signed = req_mul ? (io_req_fn[1:0] == 2'd1) : ~io_req_fn[0];
  assign req_a_neg    = req_a_signed & io_req_in1[XLEN-1];
  assign req_b_neg    = req_b_signed & io_req_in2[XLEN-1];
  assign req_a_mag    = req_a_neg ? -io_req_in1 : io_req_in1;
  assign req_b_mag    = req_b_neg ? -io_req_in2 : io_req_in2;
  assign req_b_zero   = (io_req_in2 == '0);

  // Special divides that can be answered without iterating
  logic            early_hit;
  logic [XLEN-1:0] early_result;

`ifdef ALU_DIV_EARLY_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic early_ovf;

  assign early_ovf    = ~io_req_fn[0] & (io_req_in1 == INT_MIN) & (&io_req_in2);
  assign early_hit    = io_req_fn[2] & (req_b_zero | early_ovf);
  // fn[1] selects remainder over quotient
  assign early_result = req_b_zero ? (io_req_fn[1] ? io_req_in1 : '1)
                                   : (io_req_fn[1] ? '0 : io_req_in1);
`else
  assign early_hit    = 1'b0;
  assign early_result = '0;
`endif

  // -------------------------------------------------------------------------
  // One radix-2 iteration
  // -------------------------------------------------------------------------
  // Multiply: acc = {partial product, remaining multiplier bits}; add the
  // multiplicand when the current multiplier bit is set, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;

  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                    (acc_reg[0] ? {1'b0, mcand_reg} : '0);
  assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};

  // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
  // The partial remainder stays below the divisor, so XLEN+1 bits suffice
  // for the shifted remainder and the borrow bit.
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     div_diff;
  logic              div_qbit;
  logic [2*XLEN-1:0] div_step;

  assign rem_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
  assign div_diff  = rem_shift - {1'b0, mcand_reg};
  assign div_qbit  = ~div_diff[XLEN];
  assign div_step  = {(div_qbit ? div_diff[XLEN-1:0] : rem_shift[XLEN-1:0]),
                      acc_reg[XLEN-2:0], div_qbit};

  logic [2*XLEN-1:0] step;
  assign step = fn_reg[2] ? div_step : mul_step;

  // Sign correction applied to the final iteration's output
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;
  logic [XLEN-1:0]   mul_res, div_res, md_res;

  assign prod_fix = prod_neg_reg ? -step : step;
  assign mul_res  = (fn_reg[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign quo_raw  = step[XLEN-1:0];
  assign rem_raw  = step[2*XLEN-1:XLEN];
  assign quo_fix  = prod_neg_reg ? -quo_raw : quo_raw;
  assign rem_fix  = rem_neg_reg ? -rem_raw : rem_raw;
  assign div_res  = fn_reg[1] ? rem_fix : quo_fix;
  assign md_res   = fn_reg[2] ? div_res : mul_res;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    fn_next         = fn_reg;
    prod_neg_next   = prod_neg_reg;
    rem_neg_next    = rem_neg_reg;
    acc_next        = acc_reg;
    mcand_next      = mcand_reg;
    resp_data_next  = resp_data_reg;
    resp_adder_next = resp_adder_reg;

    case (state_reg)
      IDLE: begin
        // new work is handled by the accept block below
      end
      BUSY: begin
        if (io_kill) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          acc_next   = step;
          count_next = count_reg - COUNT_ONE;
          if (count_reg == COUNT_ONE) begin
            state_next     = DONE;
            resp_data_next = md_res;
          end
        end
      end
      DONE: begin
        if (io_kill || io_resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // accept is only possible from IDLE or from a completing DONE, so it
    // overrides whatever the case above chose.
    if (accept) begin
      fn_next = io_req_fn[2:0];
      if (!io_req_md) begin
        state_next      = DONE;
        resp_data_next  = alu_result;
        resp_adder_next = alu_sum;
      end else begin
        resp_adder_next = '0;
        prod_neg_next   = req_mul ? (req_a_neg ^ req_b_neg)
                                  : ((req_a_neg ^ req_b_neg) & ~req_b_zero);
        rem_neg_next    = req_a_neg;
        acc_next        = {{XLEN{1'b0}}, (req_mul ? req_b_mag : req_a_mag)};
        mcand_next      = req_mul ? req_a_mag : req_b_mag;
        if (early_hit) begin
          state_next     = DONE;
          resp_data_next = early_result;
        end else begin
          state_next = BUSY;
          count_next = COUNT_INIT;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      fn_reg         <= '0;
      prod_neg_reg   <= 1'b0;
      rem_neg_reg    <= 1'b0;
      acc_reg        <= '0;
      mcand_reg      <= '0;
      resp_data_reg  <= '0;
      resp_adder_reg <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      fn_reg         <= fn_next;
      prod_neg_reg   <= prod_neg_next;
      rem_neg_reg    <= rem_neg_next;
      acc_reg        <= acc_next;
      mcand_reg      <= mcand_next;
      resp_data_reg  <= resp_data_next;
      resp_adder_reg <= resp_adder_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign io_req_ready  = req_ready;
  // a kill retracts a pending response in the same cycle
  assign io_resp_valid = (state_reg == DONE) & ~io_kill;
  assign io_resp_data  = resp_data_reg;
  assign io_resp_adder = resp_adder_reg;
  assign io_busy       = (state_reg != IDLE);

endmodule
